// File: rtl/pong_game_ctrl.sv
// Game sequencer for the pong datapath: serve/play/pause/miss/over flow,
// lives, session high score and the game tick.
module pong_game_ctrl #(
    parameter int TICK_CNT    = 500000,
    parameter int SERVE_TICKS = 400,
    parameter int LIVES       = 3,
    parameter int MISS_X      = 631
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic [9:0]  ball_x,
    input  logic [31:0] score,
    output logic        ball_en,
    output logic        ball_clr,
    output logic [1:0]  lives,
    output logic [31:0] high_score,
    output logic [2:0]  game_state,
    output logic        tick
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        MISS  = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam int SW = (SERVE_TICKS < 1) ? 1 : $clog2(SERVE_TICKS + 1);
    localparam logic [18:0]   TC = 19'(TICK_CNT);
    localparam logic [SW-1:0] SC = SW'(SERVE_TICKS);
    localparam logic [1:0]    LV = 2'(LIVES);
    localparam logic [9:0]    MX = 10'(MISS_X);

    state_t        state;
    logic [18:0]   tick_cnt;
    logic [SW-1:0] serve_cnt;
    logic          start_d1;
    logic          pause_d1;
    logic          tick_hit;
    logic          start_rise;
    logic          pause_rise;

    assign tick_hit   = (tick_cnt == TC);
    assign start_rise = start & ~start_d1;
    assign pause_rise = pause & ~pause_d1;
    assign game_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= tick_hit;
            tick_cnt <= tick_hit ? 19'd0 : tick_cnt + 19'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ball_en    <= 1'b0;
            ball_clr   <= 1'b0;
            lives      <= LV;
            high_score <= '0;
            serve_cnt  <= '0;
            start_d1   <= 1'b0;
            pause_d1   <= 1'b0;
        end else begin
            start_d1 <= start;
            pause_d1 <= pause;
            ball_clr <= 1'b0;
            case (state)
                IDLE: begin
                    lives   <= LV;
                    ball_en <= 1'b0;
                    if (start_rise) begin
                        state     <= SERVE;
                        ball_clr  <= 1'b1;
                        serve_cnt <= SC;
                    end
                end
                SERVE: begin
                    ball_en <= 1'b0;
                    if (tick_hit) begin
                        if (serve_cnt == '0) begin
                            state   <= PLAY;
                            ball_en <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt - 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // a miss wins over a same-cycle pause press
                    if (ball_x == MX) begin
                        state   <= MISS;
                        ball_en <= 1'b0;
                    end else if (pause_rise) begin
                        state   <= PAUSE;
                        ball_en <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (pause_rise) begin
                        state   <= PLAY;
                        ball_en <= 1'b1;
                    end
                end
                MISS: begin
                    ball_en <= 1'b0;
                    lives   <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    if (score > high_score)
                        high_score <= score;
                    if (lives == 2'd1) begin
                        state <= OVER;
                    end else begin
                        state     <= SERVE;
                        ball_clr  <= 1'b1;
                        serve_cnt <= SC;
                    end
                end
                OVER: begin
                    ball_en <= 1'b0;
                    lives   <= 2'd0;
                    if (start_rise) begin
                        state     <= SERVE;
                        lives     <= LV;
                        ball_clr  <= 1'b1;
                        serve_cnt <= SC;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ball_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed checks for pong_game_ctrl with small tick/serve parameters.
module tb_pong_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [9:0]  ball_x;
    logic [31:0] score;
    logic        ball_en;
    logic        ball_clr;
    logic [1:0]  lives;
    logic [31:0] high_score;
    logic [2:0]  game_state;
    logic        tick;

    int checks = 0;
    int errors = 0;

    pong_game_ctrl #(
        .TICK_CNT(4), .SERVE_TICKS(3), .LIVES(3), .MISS_X(631)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .ball_x(ball_x), .score(score), .ball_en(ball_en),
        .ball_clr(ball_clr), .lives(lives), .high_score(high_score),
        .game_state(game_state), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // called on the first SERVE sample; runs until PLAY or a bound
    task automatic wait_play(input bit noise);
        int n = 0;
        int t = 0;
        bit bad = 1'b0;
        while (game_state == 3'd1 && n < 40) begin
            n++;
            if (n > 1 && tick) t++;
            if (ball_en || (n > 1 && ball_clr)) bad = 1'b1;
            if (noise) begin
                pause = (n == 3);
                start = (n == 6);
            end
            @(negedge clk);
        end
        pause = 1'b0;
        start = 1'b0;
        chk("serve_exit_state", 32'(game_state), 2);
        chk("serve_exit_en", 32'(ball_en), 1);
        chk("serve_exit_tick", 32'(tick), 1);
        chk("serve_ticks", t, 3);
        chk("serve_len_ok", 32'(n >= 16 && n <= 20), 1);
        chk("serve_no_en_clr", 32'(bad), 0);
    endtask

    initial begin
        int first;
        reset = 1'b1; start = 1'b0; pause = 1'b0;
        ball_x = 10'd0; score = 32'd0;
        #12;
        chk("rst_state", 32'(game_state), 0);
        chk("rst_en", 32'(ball_en), 0);
        chk("rst_clr", 32'(ball_clr), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_hs", high_score, 0);
        chk("rst_tick", 32'(tick), 0);
        @(negedge clk); reset = 1'b0;

        // start from IDLE
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        chk("start_state", 32'(game_state), 1);
        chk("start_clr", 32'(ball_clr), 1);
        start = 1'b0;
        wait_play(1'b0);

        // first miss, score 7
        ball_x = 10'd631; score = 32'd7;
        @(negedge clk);
        chk("miss1_state", 32'(game_state), 4);
        chk("miss1_en", 32'(ball_en), 0);
        ball_x = 10'd0;
        @(negedge clk);
        chk("miss1_next", 32'(game_state), 1);
        chk("miss1_lives", 32'(lives), 2);
        chk("miss1_hs", high_score, 7);
        chk("miss1_clr", 32'(ball_clr), 1);
        wait_play(1'b1);

        // pause / resume; miss position ignored while paused
        pause = 1'b1;
        @(negedge clk);
        chk("pause_state", 32'(game_state), 3);
        chk("pause_en", 32'(ball_en), 0);
        pause = 1'b0; ball_x = 10'd631;
        @(negedge clk);
        chk("pause_miss_ign", 32'(game_state), 3);
        ball_x = 10'd0;
        @(negedge clk); pause = 1'b1;
        @(negedge clk);
        chk("resume_state", 32'(game_state), 2);
        chk("resume_en", 32'(ball_en), 1);
        chk("resume_clr", 32'(ball_clr), 0);
        pause = 1'b0;
        @(negedge clk);

        // miss coincident with pause press, lower score
        ball_x = 10'd631; score = 32'd5; pause = 1'b1;
        @(negedge clk);
        chk("miss2_state", 32'(game_state), 4);
        chk("miss2_lives_pre", 32'(lives), 2);
        ball_x = 10'd0; pause = 1'b0;
        @(negedge clk);
        chk("miss2_next", 32'(game_state), 1);
        chk("miss2_lives", 32'(lives), 1);
        chk("miss2_hs_kept", high_score, 7);
        wait_play(1'b0);
        @(negedge clk);
        chk("pause_dropped", 32'(game_state), 2);

        // last miss with start already held high
        ball_x = 10'd631; score = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        chk("miss3_state", 32'(game_state), 4);
        @(negedge clk);
        chk("over_state", 32'(game_state), 5);
        chk("over_lives", 32'(lives), 0);
        chk("over_en", 32'(ball_en), 0);
        chk("over_hs", high_score, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        chk("over_hold_start", 32'(game_state), 5);
        chk("over_hold_clr", 32'(ball_clr), 0);
        ball_x = 10'd0;
        start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        chk("restart_state", 32'(game_state), 1);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_clr", 32'(ball_clr), 1);
        start = 1'b0;
        wait_play(1'b0);

        // asynchronous reset mid-PLAY
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("amid_state", 32'(game_state), 0);
        chk("amid_en", 32'(ball_en), 0);
        chk("amid_lives", 32'(lives), 3);
        chk("amid_hs", high_score, 0);
        @(negedge clk); reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (first == 0 && tick) first = i;
        end
        chk("tick_restart", first, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
